float_accumulator_e4m3: RTL and testbench
=========================================

# float_accumulator_e4m3

Sequential E4M3 floating-point accumulator that sits directly downstream of the E4M3 multiplier. It consumes a stream of products over a valid/ready handshake, keeps a running sum in an extended-mantissa internal register, and on the element flagged `in_last` emits the E4M3 result over an output handshake before clearing for the next stream. Alignment, add/subtract and normalization are multi-cycle, with one shift per cycle.

## Interface
- `BIAS`, default 7: exponent bias for inputs, internal state and output.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  reset is synchronous and active-low.
- `in_data`  in  8  E4M3 operand: [7] sign, [6:3] biased exponent, [2:0] mantissa.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_last`  in  1  final element of the current stream.
- `in_ready`  out  1  high only in IDLE with `reset` high.
- `out_data`  out  8  E4M3 sum.
- `out_valid`  out  1  `out_data` is valid; held until accepted.
- `out_ready`  in  1  downstream accepts `out_data`.

## Operation
- Number format:
  - `[6:0]==0` is zero, with either sign.
  - Every other code is normal with an implicit leading 1.
  - No subnormals, Inf or NaN; 0x7F/0xFF are ordinary maximum magnitudes (±480).
- Internal accumulator:
  - `acc_s`, 5-bit `acc_e`, 8-bit `acc_m` (1.7 fixed point, bit 7 = implicit 1), and `acc_zero`.
  - Reset and stream start: `acc_zero`=1, all other fields 0.
- Operand expansion: `op_m = {1, in_data[2:0], 4'b0}`.
- States: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE:
  - On `in_valid & in_ready`, latch the operand and `in_last`, then go to ALIGN.
- ALIGN:
  - Operand zero: go to NORM with no change.
  - `acc_zero`: load the operand into the accumulator, go to NORM.
  - Otherwise: right-shift the mantissa of the smaller-exponent operand by the exponent difference, truncating. A difference of 8 or more makes that mantissa 0.
  - Result exponent is the larger exponent. Go to ADD.
- ADD (9-bit datapath):
  - Same signs: add. On carry, shift right 1 (truncate) and increment the exponent.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger. Equal magnitudes set `acc_zero`=1 and `acc_s`=0.
  - Go to NORM.
- NORM:
  - One cycle per step. If `!acc_zero & !acc_m[7]`, shift left 1 and decrement the exponent; otherwise exit.
  - An exponent that reaches 0 while unnormalized flushes to zero.
  - An exponent above 15 saturates to `acc_e`=15, `acc_m`=8'hFF.
  - On exit, go to OUT if the latched last flag is set, else IDLE.
- OUT:
  - `out_data` = converted accumulator; zero outputs 8'h00.
  - Hold until `out_ready`. On handshake, clear the accumulator and go to IDLE.
- Final conversion: mantissa = `acc_m[6:4]`, with rounding per Configuration.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `in_ready`=0 while `reset` is low, state IDLE, accumulator zero.
- `in_ready` is 1 in the first cycle after `reset` rises.
- Reset low on any edge aborts any state, including OUT. The pending result is discarded and never emitted.
- Per-element cycle schedule, with the operand accepted at edge T and k = left shifts in NORM (0–7):
  - ALIGN: T+1.
  - ADD: T+2. Skipped on the zero and load paths, so NORM follows ALIGN directly.
  - NORM: T+3 .. T+3+k.
  - Next state at T+4+k: IDLE, or OUT with `out_valid`=1.
- `in_ready` is 0 in every non-IDLE state; no input is accepted while the accumulator is busy or a result is pending.
- `out_data` and `out_valid` are registered and stable while `out_valid & !out_ready`.
- `out_valid` drops the cycle after the handshake.

## Configuration
- `FLOAT_ACC_RNE_EN` defined:
  - The final conversion rounds to nearest even. Guard bit = `acc_m[3]`, sticky = `|acc_m[2:0]`.
  - A mantissa carry increments the exponent. A carry out of exponent 15 saturates to 0x7F/0xFF.
- Undefined: the final conversion truncates, discarding `acc_m[3:0]`.
- The internal datapath is identical in both builds.

## Test plan
- 0x38 then 0x38 (`in_last`) -> `out_data`=0x40. `out_valid` 3 cycles after the last accept (ALIGN, ADD, one NORM cycle).
- 0x38 then 0xB8 (`in_last`) -> `out_data`=0x00 via the equal-magnitude zero path.
- 0x3C then 0xBB (`in_last`) -> `out_data`=0x20. k=3, so `out_valid` 6 cycles after the last accept.
- 0x7E then 0x7E (`in_last`) -> `out_data`=0x7F (saturation). 0xFE then 0xFE -> 0xFF.
- Rounding: 0x38 then 0x19 (`in_last`) -> 0x39 with `FLOAT_ACC_RNE_EN`, 0x38 without. 0x38 then 0x18 -> 0x38 in both builds (tie to even).
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles -> `out_data` and `out_valid` are stable throughout and `in_ready`=0.
  - Drive `reset` low for 1 cycle during NORM -> no output. A following stream of a single 0x38 (`in_last`) -> 0x38.

Source files
------------

// File: rtl/float_accumulator_e4m3.sv
// Streaming E4M3 accumulator: align, add and normalize one step per cycle, emit the sum on the last element.
// Define FLOAT_ACC_RNE_EN for round-to-nearest-even output conversion; the default build truncates.
module float_accumulator_e4m3 #(
  parameter int BIAS = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        dbg_state,
  output logic signed [5:0] dbg_exp
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // a valid source holds its data stable until that edge.
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  state_t      r_state;
  logic        r_acc_s, r_acc_zero;
  logic [4:0]  r_acc_e;
  logic [7:0]  r_acc_m;
  logic        r_op_s, r_op_zero, r_last;
  logic [3:0]  r_op_e;
  logic [7:0]  r_op_m;
  logic [7:0]  r_out_data;
  logic        r_out_valid;

  logic        w_acc_ge;
  logic [4:0]  w_diff;
  logic [8:0]  w_sum;
  logic        w_norm_exit;
  logic [4:0]  w_fin_e;
  logic [7:0]  w_fin_m;
  logic [6:0]  w_code;
  logic [7:0]  w_conv;
  logic        w_unused_bits;

  function automatic logic [7:0] shr8(input logic [7:0] m, input logic [4:0] d);
    return (d >= 5'd8) ? 8'h00 : (m >> d[2:0]);
  endfunction

  assign in_ready  = (r_state == S_IDLE) && reset;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;
  assign dbg_exp   = 6'(r_acc_e) - 6'(BIAS);

  assign w_acc_ge    = r_acc_e >= {1'b0, r_op_e};
  assign w_diff      = w_acc_ge ? (r_acc_e - {1'b0, r_op_e}) : ({1'b0, r_op_e} - r_acc_e);
  assign w_sum       = {1'b0, r_acc_m} + {1'b0, r_op_m};
  assign w_norm_exit = r_acc_zero || r_acc_m[7] || (r_acc_e > 5'd15);

  // Saturated view of the accumulator and its E4M3 encoding, used when leaving NORM.
  always_comb begin
    w_fin_e = r_acc_e;
    w_fin_m = r_acc_m;
    if (r_acc_e > 5'd15) begin
      w_fin_e = 5'd15;
      w_fin_m = 8'hFF;
    end
    w_code = {w_fin_e[3:0], w_fin_m[6:4]};
`ifdef FLOAT_ACC_RNE_EN
    if (w_fin_m[3] && ((|w_fin_m[2:0]) || w_fin_m[4]) && (w_code != 7'h7F))
      w_code = w_code + 7'd1;
`endif
    w_conv = r_acc_zero ? 8'h00 : {r_acc_s, w_code};
  end

  assign w_unused_bits = ^{w_fin_e[4], w_fin_m[7], w_fin_m[3:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc_s     <= 1'b0;
      r_acc_e     <= 5'd0;
      r_acc_m     <= 8'h00;
      r_acc_zero  <= 1'b1;
      r_op_s      <= 1'b0;
      r_op_e      <= 4'd0;
      r_op_m      <= 8'h00;
      r_op_zero   <= 1'b1;
      r_last      <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_s    <= in_data[7];
            r_op_e    <= in_data[6:3];
            r_op_m    <= {1'b1, in_data[2:0], 4'b0000};
            r_op_zero <= (in_data[6:0] == 7'd0);
            r_last    <= in_last;
            r_state   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (r_op_zero) begin
            r_state <= S_NORM;
          end else if (r_acc_zero) begin
            r_acc_s    <= r_op_s;
            r_acc_e    <= {1'b0, r_op_e};
            r_acc_m    <= r_op_m;
            r_acc_zero <= 1'b0;
            r_state    <= S_NORM;
          end else begin
            if (w_acc_ge) begin
              r_op_m <= shr8(r_op_m, w_diff);
            end else begin
              r_acc_m <= shr8(r_acc_m, w_diff);
              r_acc_e <= {1'b0, r_op_e};
            end
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (r_acc_s == r_op_s) begin
            if (w_sum[8]) begin
              r_acc_m <= w_sum[8:1];
              r_acc_e <= r_acc_e + 5'd1;
            end else begin
              r_acc_m <= w_sum[7:0];
            end
          end else if (r_acc_m > r_op_m) begin
            r_acc_m <= r_acc_m - r_op_m;
          end else if (r_acc_m < r_op_m) begin
            r_acc_m <= r_op_m - r_acc_m;
            r_acc_s <= r_op_s;
          end else begin
            r_acc_zero <= 1'b1;
            r_acc_s    <= 1'b0;
            r_acc_e    <= 5'd0;
            r_acc_m    <= 8'h00;
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (w_norm_exit) begin
            r_acc_e <= w_fin_e;
            r_acc_m <= w_fin_m;
            if (r_last) begin
              r_out_data  <= w_conv;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_state <= S_IDLE;
            end
          end else if ((r_acc_e == 5'd0) || ((r_acc_e == 5'd1) && !r_acc_m[6])) begin
            // Exponent would land on 0 with the mantissa still unnormalized.
            r_acc_zero <= 1'b1;
            r_acc_s    <= 1'b0;
            r_acc_e    <= 5'd0;
            r_acc_m    <= 8'h00;
          end else begin
            r_acc_m <= {r_acc_m[6:0], 1'b0};
            r_acc_e <= r_acc_e - 5'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc_zero  <= 1'b1;
            r_acc_s     <= 1'b0;
            r_acc_e     <= 5'd0;
            r_acc_m     <= 8'h00;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_accumulator_e4m3.sv
// Bench for float_accumulator_e4m3: directed cases, randomized streams against a reference model,
// backpressure and mid-stream reset.
module tb_float_accumulator_e4m3;

  logic              clock;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        dbg_state;
  logic signed [5:0] dbg_exp;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  int         lat_q[$];

`ifdef FLOAT_ACC_RNE_EN
  localparam logic [7:0] ROUND_CASE = 8'h39;
`else
  localparam logic [7:0] ROUND_CASE = 8'h38;
`endif

  logic [7:0] dir_a[7];
  logic [7:0] dir_b[7];
  logic [7:0] dir_r[7];
  int         dir_l[7];

  float_accumulator_e4m3 #(.BIAS(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state),
    .dbg_exp   (dbg_exp)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference model: signed integer sum of mantissas on a common exponent.
  function automatic logic [7:0] encode(input bit s, input int e, input int m);
    int q;
    logic [7:0] r;
    q = m / 16;
`ifdef FLOAT_ACC_RNE_EN
    if ((m % 16) > 8 || ((m % 16) == 8 && (q % 2) == 1)) q++;
    if (q == 16) begin q = 8; e++; end
    if (e > 15) begin e = 15; q = 15; end
`endif
    r[7]   = s;
    r[6:3] = 4'(e);
    r[2:0] = 3'(q - 8);
    return r;
  endfunction

  function automatic logic [7:0] model_stream();
    bit z = 1'b1;
    bit s = 1'b0;
    int e = 0;
    int m = 0;
    int xe, xm, big_e, a, b, sum, k;
    logic [7:0] x;
    lat_q.delete();
    foreach (stim_q[i]) begin
      x  = stim_q[i];
      xe = int'(x[6:3]);
      xm = 128 + 16 * int'(x[2:0]);
      if (x[6:0] == 7'd0) begin
        lat_q.push_back(2);
      end else if (z) begin
        z = 1'b0; s = x[7]; e = xe; m = xm;
        lat_q.push_back(2);
      end else begin
        big_e = (e > xe) ? e : xe;
        a     = m >> (big_e - e);
        b     = xm >> (big_e - xe);
        sum   = (s ? -a : a) + (x[7] ? -b : b);
        k     = 0;
        if (sum == 0) begin
          z = 1'b1; s = 1'b0; e = 0; m = 0;
        end else begin
          s = (sum < 0);
          m = s ? -sum : sum;
          e = big_e;
          if (m >= 256) begin m = m / 2; e++; end
          while (m < 128 && !z) begin
            k++;
            if (e == 0 || (e == 1 && m < 64)) begin z = 1'b1; s = 1'b0; e = 0; m = 0; end
            else begin m = m * 2; e--; end
          end
          if (e > 15) begin e = 15; m = 255; end
        end
        lat_q.push_back(3 + k);
      end
    end
    return z ? 8'h00 : encode(s, e, m);
  endfunction

  function automatic logic [7:0] rand_elem();
    logic [7:0] x;
    if ($urandom_range(0, 7) == 0) x = {1'($urandom_range(0, 1)), 7'h00};
    else x = {1'($urandom_range(0, 1)), 4'($urandom_range(8, 15)), 3'($urandom_range(0, 7))};
    return x;
  endfunction

  // Driver: sends stim_q as one stream and checks each element's latency against lat_q.
  task automatic drive_stream(input string name, input bit abort_last);
    int n;
    bit last;
    for (int i = 0; i < stim_q.size(); i++) begin
      last = (i == stim_q.size() - 1);
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_wait elem %0d: got %b want 1", name, i, in_ready);
        return;
      end
      in_data = stim_q[i]; in_valid = 1'b1; in_last = last;
      @(negedge clock);
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      if (last && abort_last) return;
      n = 0;
      while ((last ? out_valid : in_ready) !== 1'b1 && n < 40) begin @(negedge clock); n++; end
      checks++;
      if (n != lat_q[i]) begin
        errors++;
        $display("FAIL %s latency elem %0d: got %0d want %0d", name, i, n, lat_q[i]);
      end
    end
  endtask

  // Scoreboard: compares the pending result, optionally holds it off, then completes the handshake.
  task automatic collect_output(input string name, input int hold);
    logic [7:0] exp, held;
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got data %h valid %b ready %b want data %h valid 1 ready 0",
               name, out_data, out_valid, in_ready, exp);
    end
    held = out_data;
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold cycle %0d: got data %h valid %b ready %b want data %h valid 1 ready 0",
                 name, c, out_data, out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got valid %b ready %b want valid 0 ready 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: got ready %b valid %b data %h state %0d want 0 0 00 0",
               in_ready, out_valid, out_data, dbg_state);
    end
    checks++;
    if (dbg_exp !== -6'sd7) begin
      errors++;
      $display("FAIL reset_exp: got %0d want -7", dbg_exp);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_directed();
    dir_a = '{8'h38, 8'h38, 8'h3C, 8'h7E, 8'hFE, 8'h38, 8'h38};
    dir_b = '{8'h38, 8'hB8, 8'hBB, 8'h7E, 8'hFE, 8'h19, 8'h18};
    dir_r = '{8'h40, 8'h00, 8'h20, 8'h7F, 8'hFF, ROUND_CASE, 8'h38};
    dir_l = '{3, 3, 6, 3, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      stim_q = '{dir_a[i], dir_b[i]};
      lat_q  = '{2, dir_l[i]};
      exp_q.push_back(dir_r[i]);
      drive_stream($sformatf("directed_%0d", i), 1'b0);
      collect_output($sformatf("directed_%0d", i), 0);
    end
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(1, 6);
      stim_q.delete();
      for (int j = 0; j < len; j++) stim_q.push_back(rand_elem());
      exp_q.push_back(model_stream());
      drive_stream($sformatf("random_%0d", t), 1'b0);
      collect_output($sformatf("random_%0d", t), $urandom_range(0, 2));
    end
  endtask

  task automatic test_backpressure();
    stim_q = '{8'h38, 8'h38};
    lat_q  = '{2, 3};
    exp_q.push_back(8'h40);
    drive_stream("backpressure", 1'b0);
    collect_output("backpressure", 5);
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    stim_q = '{8'h3C, 8'hBB};
    lat_q  = '{2, 6};
    drive_stream("abort", 1'b1);
    repeat (2) @(negedge clock);
    checks++;
    if (dbg_state !== 3'd3) begin
      errors++;
      $display("FAIL abort_in_norm: got state %0d want 3", dbg_state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready_low: got %b want 0", in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clock);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    stim_q = '{8'h38};
    lat_q  = '{2};
    exp_q.push_back(8'h38);
    drive_stream("after_abort", 1'b0);
    collect_output("after_abort", 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
